memoria_arbitro: RTL and testbench

MEMORIA_ARBITRO -- requirements
Module: memoria_arbitro

---
 rtl/memoria_pkg.sv | 12 +
 rtl/memoria_rr_pick.sv | 62 ++++++
 rtl/memoria_arbitro.sv | 94 +++++++++
 tb/tb_memoria_arbitro.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/memoria_pkg.sv
// memoria_pkg: shared defaults and constants for the dual-port memory arbiter.
package memoria_pkg;
    localparam int NREQ_DEF   = 4;
    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 4;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/memoria_rr_pick.sv
// memoria_rr_pick: combinational two-winner round-robin pick with port-B address conflict check.
module memoria_rr_pick
    import memoria_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int PTR_W = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        rw_i,
    input  logic [NREQ*ADDR_W-1:0] addr_i,
    input  logic [PTR_W-1:0]       ptr_i,
    output logic                   a_vld_o,
    output logic [PTR_W-1:0]       a_idx_o,
    output logic                   b_vld_o,
    output logic [PTR_W-1:0]       b_idx_o,
    output logic [NREQ-1:0]        gnt_o,
    output logic [PTR_W-1:0]       nxt_o
);
    logic [PTR_W:0]    s, n;
    logic [PTR_W-1:0]  j, last;
    logic [ADDR_W-1:0] a_addr;
    logic              a_rw, seen_b;

    // Only the requester immediately after the port-A winner may take port B.
    always_comb begin
        a_vld_o = 1'b0;
        b_vld_o = 1'b0;
        a_idx_o = '0;
        b_idx_o = '0;
        a_addr = '0;
        a_rw = RW_READ;
        seen_b = 1'b0;
        s = '0;
        j = '0;
        for (int k = 0; k < NREQ; k++) begin
            s = {1'b0, ptr_i} + (PTR_W+1)'(k);
            s = (s >= (PTR_W+1)'(NREQ)) ? s - (PTR_W+1)'(NREQ) : s;
            j = s[PTR_W-1:0];
            if (req_i[j] && !a_vld_o) begin
                a_vld_o = 1'b1;
                a_idx_o = j;
                a_addr = addr_i[j*ADDR_W +: ADDR_W];
                a_rw = rw_i[j];
            end else if (req_i[j] && !seen_b) begin
                seen_b = 1'b1;
                b_vld_o = !(addr_i[j*ADDR_W +: ADDR_W] == a_addr &&
                            (a_rw == RW_WRITE || rw_i[j] == RW_WRITE));
                b_idx_o = j;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        gnt_o[a_idx_o] = a_vld_o;
        if (b_vld_o) gnt_o[b_idx_o] = 1'b1;
        last = b_vld_o ? b_idx_o : a_idx_o;
        n = {1'b0, last} + 1'b1;
        nxt_o = !a_vld_o ? ptr_i : (n == (PTR_W+1)'(NREQ)) ? '0 : n[PTR_W-1:0];
    end
endmodule

// File: rtl/memoria_arbitro.sv
// memoria_arbitro: shares a dual-port memory among NREQ requesters, two grants per cycle,
// registered port drive and a fixed two-cycle read return.
module memoria_arbitro
    import memoria_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_rw,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [NREQ*DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]        AddrA,
    output logic [ADDR_W-1:0]        AddrB,
    output logic                     rwA,
    output logic                     rwB,
    output logic [DATA_W-1:0]        DataInA,
    output logic [DATA_W-1:0]        DataInB,
    input  logic [DATA_W-1:0]        DataOutA,
    input  logic [DATA_W-1:0]        DataOutB
);
    localparam int PTR_W = ptr_w(NREQ);

    logic [PTR_W-1:0]             ptr_q, ptr_d, a_idx, b_idx;
    logic                         a_vld, b_vld;
    logic [NREQ-1:0]              pick_gnt;
    logic [1:0]                   pv, rw_q, v1_q, rd2_q;
    logic [1:0][PTR_W-1:0]        pidx, i1_q, i2_q;
    logic [1:0][ADDR_W-1:0]       addr_q;
    logic [1:0][DATA_W-1:0]       din_q, dout;

    memoria_rr_pick #(.NREQ(NREQ), .ADDR_W(ADDR_W)) u_pick (
        .req_i   (req),
        .rw_i    (req_rw),
        .addr_i  (req_addr),
        .ptr_i   (ptr_q),
        .a_vld_o (a_vld),
        .a_idx_o (a_idx),
        .b_vld_o (b_vld),
        .b_idx_o (b_idx),
        .gnt_o   (pick_gnt),
        .nxt_o   (ptr_d)
    );

    assign pv = {b_vld, a_vld};
    assign pidx = {b_idx, a_idx};
    assign dout = {DataOutB, DataOutA};
    assign gnt = reset_L ? pick_gnt : '0;
    assign {AddrB, AddrA} = addr_q;
    assign {rwB, rwA} = rw_q;
    assign {DataInB, DataInA} = din_q;

    // Index 0 is port A, index 1 is port B; stage 1 rides with the port registers.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            ptr_q <= '0;
            addr_q <= '0;
            rw_q <= '0;
            din_q <= '0;
            v1_q <= '0;
            i1_q <= '0;
            rd2_q <= '0;
            i2_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            for (int p = 0; p < 2; p++) begin
                v1_q[p] <= pv[p];
                i1_q[p] <= pidx[p];
                addr_q[p] <= pv[p] ? req_addr[pidx[p]*ADDR_W +: ADDR_W] : '0;
                rw_q[p] <= pv[p] ? req_rw[pidx[p]] : RW_READ;
                din_q[p] <= pv[p] ? req_wdata[pidx[p]*DATA_W +: DATA_W] : '0;
                rd2_q[p] <= v1_q[p] && rw_q[p] == RW_READ;
                i2_q[p] <= i1_q[p];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        rdata = '0;
        for (int p = 0; p < 2; p++) begin
            if (reset_L && rd2_q[p]) begin
                rvalid[i2_q[p]] = 1'b1;
                rdata[i2_q[p]*DATA_W +: DATA_W] = dout[p];
            end
        end
    end
endmodule

// File: tb/tb_memoria_arbitro.sv
// tb_memoria_arbitro: directed bench for memoria_arbitro with a registered dual-port memory model.
module tb_memoria_arbitro;
    logic        clk = 1'b0;
    logic        reset_L;
    logic [3:0]  req, req_rw, gnt, rvalid;
    logic [11:0] req_addr;
    logic [15:0] req_wdata, rdata;
    logic [2:0]  AddrA, AddrB;
    logic        rwA, rwB;
    logic [3:0]  DataInA, DataInB, DataOutA, DataOutB;
    logic [3:0]  mem [8] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  rw;
        logic [11:0] addr;
        logic [3:0]  gnt;
    } vec_t;
    vec_t tv [15];

    memoria_arbitro dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .AddrA     (AddrA),
        .AddrB     (AddrB),
        .rwA       (rwA),
        .rwB       (rwB),
        .DataInA   (DataInA),
        .DataInB   (DataInB),
        .DataOutA  (DataOutA),
        .DataOutB  (DataOutB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rwA) mem[AddrA] <= DataInA;
        if (rwB) mem[AddrB] <= DataInB;
        DataOutA <= mem[AddrA];
        DataOutB <= mem[AddrB];
    end

    function automatic logic [11:0] pa(input int a0, input int a1, input int a2, input int a3);
        return {3'(a3), 3'(a2), 3'(a1), 3'(a0)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = '0;
        req_rw = '0;
        req_addr = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        idle();
        reset_L = 1'b0;
        nxt();
        nxt();
        reset_L = 1'b1;
    endtask

    initial begin
        tv[0]  = '{4'b0001, 4'b0000, pa(0, 1, 2, 3), 4'b0001};
        tv[1]  = '{4'b1111, 4'b0000, pa(0, 1, 2, 3), 4'b0110};
        tv[2]  = '{4'b1111, 4'b0000, pa(0, 1, 2, 3), 4'b1001};
        tv[3]  = '{4'b0000, 4'b0000, pa(0, 0, 0, 0), 4'b0000};
        tv[4]  = '{4'b0001, 4'b0000, pa(1, 0, 0, 0), 4'b0001};
        tv[5]  = '{4'b1000, 4'b0000, pa(0, 0, 0, 2), 4'b1000};
        tv[6]  = '{4'b0011, 4'b0001, pa(3, 3, 0, 0), 4'b0001};
        tv[7]  = '{4'b0110, 4'b0010, pa(0, 4, 4, 0), 4'b0010};
        tv[8]  = '{4'b1100, 4'b1100, pa(0, 0, 5, 6), 4'b1100};
        tv[9]  = '{4'b1010, 4'b0000, pa(0, 7, 0, 7), 4'b1010};
        tv[10] = '{4'b0101, 4'b0100, pa(2, 0, 2, 0), 4'b0001};
        tv[11] = '{4'b1101, 4'b0000, pa(1, 0, 2, 3), 4'b1100};
        tv[12] = '{4'b1111, 4'b0010, pa(0, 0, 0, 0), 4'b0001};
        tv[13] = '{4'b1110, 4'b0010, pa(0, 0, 0, 0), 4'b0010};
        tv[14] = '{4'b1100, 4'b0000, pa(0, 0, 1, 2), 4'b1100};

        idle();
        reset_L = 1'b0;
        req = 4'hF;
        for (int c = 0; c < 2; c++) begin
            nxt();
            @(negedge clk);
            chk("rst_gnt", gnt, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_addr", {AddrA, AddrB}, 0);
            chk("rst_rw", {rwA, rwB}, 0);
        end
        nxt();
        idle();
        reset_L = 1'b1;

        for (int i = 0; i < 15; i++) begin
            req = tv[i].req;
            req_rw = tv[i].rw;
            req_addr = tv[i].addr;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), gnt, tv[i].gnt);
            nxt();
        end

        // write then read back from requester 1
        do_reset();
        req = 4'b0010; req_rw = 4'b0010; req_addr[3 +: 3] = 3'd5; req_wdata[4 +: 4] = 4'hA;
        @(negedge clk); chk("wr_gnt", gnt, 4'b0010);
        nxt(); idle();
        @(negedge clk);
        chk("wr_portA", {AddrA, rwA, DataInA}, {3'd5, 1'b1, 4'hA});
        chk("wr_portB_idle", {AddrB, rwB, DataInB}, 0);
        chk("wr_gnt_idle", gnt, 0);
        nxt();
        req = 4'b0010; req_addr[3 +: 3] = 3'd5;
        @(negedge clk); chk("rd_gnt", gnt, 4'b0010);
        nxt(); idle();
        @(negedge clk);
        chk("rd_rvalid_early", rvalid, 0);
        chk("rd_portA", {AddrA, rwA}, {3'd5, 1'b0});
        nxt();
        @(negedge clk);
        chk("rd_rvalid", rvalid, 4'b0010);
        chk("rd_rdata", rdata[4 +: 4], 4'hA);
        nxt();
        @(negedge clk); chk("rd_rvalid_pulse", rvalid, 0);

        // fairness: everyone reads continuously
        do_reset();
        req = 4'hF; req_addr = pa(0, 1, 2, 3);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("fair%0d_gnt", c), gnt, (c % 2 == 0) ? 4'b0011 : 4'b1100);
            chk($sformatf("fair%0d_rvalid", c), rvalid,
                (c < 2) ? 4'b0000 : (c % 2 == 0) ? 4'b0011 : 4'b1100);
            nxt();
        end

        // write/read conflict on the same address
        do_reset();
        req = 4'b0011; req_rw = 4'b0001; req_addr = pa(3, 3, 0, 0); req_wdata[3:0] = 4'h6;
        @(negedge clk); chk("cf_gnt0", gnt, 4'b0001);
        nxt();
        req = 4'b0010; req_rw = 4'b0000;
        @(negedge clk);
        chk("cf_gnt1", gnt, 4'b0010);
        chk("cf_portA", {AddrA, rwA, DataInA}, {3'd3, 1'b1, 4'h6});
        nxt(); idle();
        @(negedge clk); chk("cf_rvalid_early", rvalid, 0);
        nxt();
        @(negedge clk);
        chk("cf_rvalid", rvalid, 4'b0010);
        chk("cf_rdata", rdata[4 +: 4], 4'h6);
        nxt();

        // two reads of the same address share a cycle
        do_reset();
        req = 4'b1100; req_addr = pa(0, 0, 7, 7);
        @(negedge clk); chk("sa_gnt", gnt, 4'b1100);
        nxt(); idle();
        @(negedge clk);
        chk("sa_ports", {AddrA, rwA, AddrB, rwB}, {3'd7, 1'b0, 3'd7, 1'b0});
        nxt();
        @(negedge clk);
        chk("sa_rvalid", rvalid, 4'b1100);
        chk("sa_rdata", rdata[15:8], 8'hFF);
        nxt();

        // reset lands while a read is in flight
        do_reset();
        req = 4'b0001; req_addr = pa(7, 0, 0, 0);
        @(negedge clk); chk("mr_gnt", gnt, 4'b0001);
        nxt(); idle(); reset_L = 1'b0;
        @(negedge clk); chk("mr_gnt_rst", gnt, 0);
        nxt(); reset_L = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk($sformatf("mr_rvalid%0d", c), rvalid, 0);
            nxt();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
